// File: rtl/dbg_sipo_pkg.sv
// Shared definitions for the debug SIPO deserialiser.
//   st_e       : frame-alignment state (ST_IDLE unaligned, ST_ACT aligned)
//   tflog2     : ceil(log2(n)), never below 1, used to size the beat counter
//   width_ok   : build-time legality of an (ODAT_B, IDAT_B) pair
package dbg_sipo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACT  = 1'b1
  } st_e;

  function automatic int tflog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // The word must split into a whole number of beats.
  function automatic bit width_ok(input int odat_b, input int idat_b);
    return (idat_b > 0) && (odat_b >= idat_b) && ((odat_b % idat_b) == 0);
  endfunction

endpackage

// File: rtl/dbg_sipo_asm.sv
// Word assembler: beat counter, assembly buffer and beat-position mux.
//   wr      : accept the beat in dat this cycle
//   restart : place this beat at position 0 regardless of cnt
//   dat     : beat data
//   cnt     : next beat position (0..NBEAT-1)
//   done    : the beat being written completes a word
//   word    : buffer contents with the current beat merged in
module dbg_sipo_asm
  import dbg_sipo_pkg::*;
#(
  parameter int IDAT_B    = 2,
  parameter int NBEAT     = 16,
  parameter int CNT_B     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic                    restart,
  input  logic [IDAT_B-1:0]       dat,
  output logic [CNT_B-1:0]        cnt,
  output logic                    done,
  output logic [NBEAT*IDAT_B-1:0] word
);

  localparam logic [CNT_B-1:0] LAST = CNT_B'(NBEAT - 1);

  logic [CNT_B-1:0]                 pos;
  logic [CNT_B-1:0]                 lane;
  logic [CNT_B-1:0]                 cnt_nxt;
  logic [NBEAT-1:0][IDAT_B-1:0]     asm_q;
  logic [NBEAT-1:0][IDAT_B-1:0]     merged;

  assign pos     = restart ? '0 : cnt;
  // MSB-first streams fill the buffer from the top lane downward.
  assign lane    = (MSB_FIRST != 0) ? (LAST - pos) : pos;
  assign done    = wr && (pos == LAST);
  assign cnt_nxt = done ? '0 : (pos + CNT_B'(1));

  for (genvar k = 0; k < NBEAT; k++) begin : g_lane
    assign merged[k] = (wr && (lane == CNT_B'(k))) ? dat : asm_q[k];
  end

  // The buffer is never cleared between words: stale lanes are always
  // overwritten before a completion can expose them.
  fflopknx #(.W(NBEAT*IDAT_B)) u_asm (
    .clk(clk), .rst(rst), .en(wr), .d(merged), .q(asm_q)
  );

  fflopknx #(.W(CNT_B)) u_cnt (
    .clk(clk), .rst(rst), .en(wr), .d(cnt_nxt), .q(cnt)
  );

  assign word = merged;

endmodule

// File: rtl/fflopknx.sv
// Enabled flop cell with synchronous active-low clear.
//   clk : rising-edge clock
//   rst : synchronous clear, active low (wins over en)
//   en  : load enable
//   d/q : data in / registered data out
module fflopknx #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dbg_sipo_frame.sv
// Debug serial-in/parallel-out deserialiser with frame-start alignment.
//   clk, rst : clock, synchronous active-low reset
//   ivld     : beat valid (iena/idat ignored when low)
//   iena     : frame start, marks beat 0 of a word
//   idat     : beat data
//   odat     : last completed word, held until the next completion
//   ovld     : one-cycle pulse with each new odat
//   oerr     : one-cycle pulse on a truncated frame
//   osync    : high while frame-aligned
module dbg_sipo_frame
  import dbg_sipo_pkg::*;
#(
  parameter int ODAT_B    = 32,
  parameter int IDAT_B    = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ivld,
  input  logic              iena,
  input  logic [IDAT_B-1:0] idat,
  output logic [ODAT_B-1:0] odat,
  output logic              ovld,
  output logic              oerr,
  output logic              osync
);

  localparam int NBEAT = ODAT_B / IDAT_B;
  localparam int CNT_B = tflog2(NBEAT);

  if (!width_ok(ODAT_B, IDAT_B)) begin : g_bad_width
    $error("dbg_sipo_frame: ODAT_B must be a multiple of IDAT_B");
  end

  // Input stage: pad-facing registers, nothing decided before them.
  logic [IDAT_B+1:0] stg_q;
  logic              s_vld;
  logic              s_ena;
  logic [IDAT_B-1:0] s_dat;

  fflopknx #(.W(IDAT_B+2)) u_stage (
    .clk(clk), .rst(rst), .en(1'b1), .d({ivld, iena, idat}), .q(stg_q)
  );

  assign s_vld = stg_q[IDAT_B+1];
  assign s_ena = stg_q[IDAT_B];
  assign s_dat = stg_q[IDAT_B-1:0];

  // FSM
  logic              st_q;
  st_e               state;
  st_e               st_nxt;
  logic              wr;
  logic              restart;
  logic              err;
  logic [CNT_B-1:0]  cnt;
  logic              done;
  logic [ODAT_B-1:0] word;

  assign state = st_e'(st_q);

  fflopknx #(.W(1)) u_state (
    .clk(clk), .rst(rst), .en(1'b1), .d(st_nxt), .q(st_q)
  );

  always_comb begin
    st_nxt  = state;
    wr      = 1'b0;
    restart = 1'b0;
    err     = 1'b0;
    if (s_vld) begin
      unique case (state)
        ST_IDLE: begin
          if (s_ena) begin
            wr      = 1'b1;
            restart = 1'b1;
            st_nxt  = ST_ACT;
          end
        end
        ST_ACT: begin
          wr = 1'b1;
          // A frame start mid-word truncates the partial word; the marker
          // beat itself becomes beat 0 of the next word.
          if (s_ena && (cnt != '0)) begin
            restart = 1'b1;
            err     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  dbg_sipo_asm #(
    .IDAT_B(IDAT_B), .NBEAT(NBEAT), .CNT_B(CNT_B), .MSB_FIRST(MSB_FIRST)
  ) u_asm (
    .clk(clk), .rst(rst), .wr(wr), .restart(restart), .dat(s_dat),
    .cnt(cnt), .done(done), .word(word)
  );

  // Output registers
  logic [1:0] flg_q;

  fflopknx #(.W(ODAT_B)) u_odat (
    .clk(clk), .rst(rst), .en(done), .d(word), .q(odat)
  );

  fflopknx #(.W(2)) u_flags (
    .clk(clk), .rst(rst), .en(1'b1), .d({done, err}), .q(flg_q)
  );

  assign ovld  = flg_q[1];
  assign oerr  = flg_q[0];
  assign osync = (state == ST_ACT);

endmodule

// File: tb/tb_dbg_sipo_frame.sv
module tb_dbg_sipo_frame;
  localparam int ODAT_B = 8;
  localparam int IDAT_B = 2;
  localparam int NBEAT  = ODAT_B / IDAT_B;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ivld = 1'b0;
  logic              iena = 1'b0;
  logic [IDAT_B-1:0] idat = '0;
  logic [ODAT_B-1:0] odat0, odat1;
  logic              ovld0, ovld1, oerr0, oerr1, osync0, osync1;

  always #5 clk = ~clk;

  dbg_sipo_frame #(.ODAT_B(ODAT_B), .IDAT_B(IDAT_B), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .ivld(ivld), .iena(iena), .idat(idat),
    .odat(odat0), .ovld(ovld0), .oerr(oerr0), .osync(osync0)
  );

  dbg_sipo_frame #(.ODAT_B(ODAT_B), .IDAT_B(IDAT_B), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .ivld(ivld), .iena(iena), .idat(idat),
    .odat(odat1), .ovld(ovld1), .oerr(oerr1), .osync(osync1)
  );

  int errs   = 0;
  int checks = 0;

  // Reference model: list of beats gathered for the current word.
  bit          aligned;
  int          n;
  int          beats[NBEAT];
  logic [7:0]  m_lsb, m_msb;

  typedef struct {
    logic       ovld;
    logic       oerr;
    logic       osync;
    logic [7:0] lsb;
    logic [7:0] msb;
  } exp_t;

  exp_t exp_prev, exp_now;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    chk("ovld_lsb",  32'(ovld0),  32'(e.ovld));
    chk("ovld_msb",  32'(ovld1),  32'(e.ovld));
    chk("oerr_lsb",  32'(oerr0),  32'(e.oerr));
    chk("oerr_msb",  32'(oerr1),  32'(e.oerr));
    chk("osync_lsb", 32'(osync0), 32'(e.osync));
    chk("osync_msb", 32'(osync1), 32'(e.osync));
    chk("odat_lsb",  32'(odat0),  32'(e.lsb));
    chk("odat_msb",  32'(odat1),  32'(e.msb));
  endtask

  // One cycle: present a beat, update the model, then check the outputs,
  // which reflect the beat presented one step earlier (latency 2).
  task automatic step(input bit v, input bit e, input logic [IDAT_B-1:0] d);
    @(negedge clk);
    rst = 1'b1; ivld = v; iena = e; idat = d;
    exp_now.ovld = 1'b0;
    exp_now.oerr = 1'b0;
    if (v) begin
      if (!aligned) begin
        if (e) begin aligned = 1'b1; beats[0] = int'(d); n = 1; end
      end else begin
        if (e && n != 0) begin exp_now.oerr = 1'b1; n = 0; end
        beats[n] = int'(d);
        n++;
      end
      if (aligned && n == NBEAT) begin
        m_lsb = '0; m_msb = '0;
        for (int k = 0; k < NBEAT; k++) begin
          m_lsb = m_lsb | 8'(beats[k] << (k * IDAT_B));
          m_msb = m_msb | 8'(beats[k] << ((NBEAT - 1 - k) * IDAT_B));
        end
        exp_now.ovld = 1'b1;
        n = 0;
      end
    end
    exp_now.osync = aligned;
    exp_now.lsb   = m_lsb;
    exp_now.msb   = m_msb;
    @(posedge clk); #1;
    cmp_all(exp_prev);
    exp_prev = exp_now;
  endtask

  // Reset for one cycle with a (lost) frame-start beat on the pins.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ivld = 1'b1; iena = 1'b1; idat = IDAT_B'($urandom);
    @(posedge clk); #1;
    chk("rst_odat0", 32'(odat0), 32'h0);
    chk("rst_odat1", 32'(odat1), 32'h0);
    chk("rst_ovld",  32'(ovld0 | ovld1), 32'h0);
    chk("rst_oerr",  32'(oerr0 | oerr1), 32'h0);
    chk("rst_osync", 32'(osync0 | osync1), 32'h0);
    aligned = 1'b0; n = 0; m_lsb = '0; m_msb = '0;
    exp_prev = '{ovld: 1'b0, oerr: 1'b0, osync: 1'b0, lsb: 8'h0, msb: 8'h0};
  endtask

  task automatic frame(input logic [7:0] w, input bit ena_first, input int gap);
    for (int k = 0; k < NBEAT; k++) begin
      logic [7:0] t;
      t = w >> (k * IDAT_B);
      step(1'b1, ena_first && (k == 0), t[1:0]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b1, 2'(k));
    end
  endtask

  initial begin
    aligned = 1'b0; n = 0; m_lsb = '0; m_msb = '0;
    exp_prev = '{ovld: 1'b0, oerr: 1'b0, osync: 1'b0, lsb: 8'h0, msb: 8'h0};
    do_reset();
    do_reset();

    // Unaligned beats and a frame start without ivld: all ignored.
    step(1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b11);
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);

    // Basic word: beats 01,10,11,00.
    step(1'b1, 1'b1, 2'b01);
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    chk("plan_lsb", 32'(odat0), 32'h39);
    chk("plan_msb", 32'(odat1), 32'h6C);
    chk("plan_vld", 32'(ovld0 & ovld1 & osync0), 32'h1);
    step(1'b0, 1'b0, 2'b00);

    // Back-to-back words, second without iena; then with ivld gaps.
    frame(8'hA5, 1'b1, 0);
    frame(8'h3C, 1'b0, 0);
    frame(8'h96, 1'b1, 3);
    frame(8'h1E, 1'b0, 3);
    step(1'b0, 1'b0, 2'b00);

    // Short frame: iena, one beat, iena again -> oerr, then a full word.
    step(1'b1, 1'b1, 2'b10);
    step(1'b1, 1'b0, 2'b01);
    frame(8'hC6, 1'b1, 0);
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);

    // Reset mid-word, then a fresh frame with no stale bits.
    step(1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b0, 2'b11);
    do_reset();
    frame(8'h04, 1'b1, 0);
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);

    // Randomised stream.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                IDAT_B'($urandom));
    end
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
